// File: rtl/shift_iter.sv
// shift_iter: iterative one-bit-per-cycle shifter with an IDLE/SHIFT/DONE FSM.
// Define SHIFT_ITER_ARITH_EN to add the arith port and arithmetic right shifts.
module shift_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] A,
    input  logic        ir,
    input  logic [3:0]  amt,
`ifdef SHIFT_ITER_ARITH_EN
    input  logic        arith,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] Y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] work;
    logic [15:0] work_sh;
    logic [3:0]  cnt;
    logic        dir;
    logic        fill;

`ifdef SHIFT_ITER_ARITH_EN
    logic        arith_q;

    // Replicating work[15] keeps the captured sign bit for every step.
    assign fill = arith_q & dir & work[15];
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        work_sh = {work[14:0], 1'b0};
        if (dir) begin
            work_sh = {fill, work[15:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (amt == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'd1) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Operands are captured only in IDLE, so late starts and input changes are inert.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work    <= '0;
            cnt     <= '0;
            dir     <= 1'b0;
            Y       <= '0;
`ifdef SHIFT_ITER_ARITH_EN
            arith_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work    <= A;
                        dir     <= ir;
                        cnt     <= amt;
`ifdef SHIFT_ITER_ARITH_EN
                        arith_q <= arith;
`endif
                        if (amt == 4'd0) begin
                            Y <= A;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_sh;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        Y <= work_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
